// File: rtl/spc_stack_ctl.sv
// spc_stack_ctl: subroutine-pointer-control stack controller.
// Owns the 5-bit SPC stack pointer and the live-entry count. It turns push
// and pop requests into accesses on a 32x19 synchronous SPC RAM and keeps a
// registered copy of the top-of-stack word.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   push, pop         commands; accepted only while busy=0 (both = replace top)
//   push_data         word to push or replace
//   clr_flags         clears sticky overflow/underflow
//   tos, tos_valid    registered top-of-stack word and its validity
//   busy              pop refetch in progress; commands are ignored
//   spcptr, depth     stack pointer (address of TOS) and live entries 0..32
//   overflow          sticky; set by a push at depth 32
//   underflow         sticky; set by a pop at depth 0
//   ram_address, ram_data, ram_wren, ram_rden
//                     RAM request, decoded in the issuing cycle
//   ram_q             RAM read data, valid READ_LATENCY cycles after ram_rden
module spc_stack_ctl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [18:0] push_data,
  input  logic        clr_flags,
  output logic [18:0] tos,
  output logic        tos_valid,
  output logic        busy,
  output logic [4:0]  spcptr,
  output logic [5:0]  depth,
  output logic        overflow,
  output logic        underflow,
  output logic [4:0]  ram_address,
  output logic [18:0] ram_data,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [18:0] ram_q
);

  localparam int unsigned PTR_W     = 5;
  localparam int unsigned DEPTH_W   = 6;
  localparam int unsigned DATA_W    = 19;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned MAX_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_d;
  logic [DEPTH_W-1:0] depth_d;
  logic [DATA_W-1:0]  tos_d;
  logic               tos_valid_d;
  logic               busy_d;
  logic               overflow_d;
  logic               underflow_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      spcptr    <= '0;
      depth     <= '0;
      tos       <= '0;
      tos_valid <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spcptr    <= ptr_d;
      depth     <= depth_d;
      tos       <= tos_d;
      tos_valid <= tos_valid_d;
      busy      <= busy_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

  // Next-state, register updates and RAM request decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = spcptr;
    depth_d     = depth;
    tos_d       = tos;
    tos_valid_d = tos_valid;
    busy_d      = busy;
    // A flag-setting event below overrides the clear.
    overflow_d  = overflow & ~clr_flags;
    underflow_d = underflow & ~clr_flags;
    ram_address = spcptr;
    ram_data    = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;

    case (state_q)
      IDLE: begin
        if (push && pop) begin
          // Replace top: overwrite in place, pointer and depth unchanged.
          ram_data    = push_data;
          ram_wren    = 1'b1;
          tos_d       = push_data;
          tos_valid_d = 1'b1;
        end else if (push) begin
          ram_address = spcptr + PTR_W'(1);
          ram_data    = push_data;
          ram_wren    = 1'b1;
          ptr_d       = spcptr + PTR_W'(1);
          tos_d       = push_data;
          tos_valid_d = 1'b1;
          if (depth == DEPTH_W'(MAX_DEPTH)) begin
            overflow_d = 1'b1;
          end else begin
            depth_d = depth + DEPTH_W'(1);
          end
        end else if (pop) begin
          // Read the entry beneath TOS; it becomes TOS once ram_q returns.
          ram_address = spcptr - PTR_W'(1);
          ram_rden    = 1'b1;
          ptr_d       = spcptr - PTR_W'(1);
          tos_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = FETCH;
          cnt_d       = CNT_W'(READ_LATENCY);
          if (depth == '0) begin
            underflow_d = 1'b1;
          end else begin
            depth_d = depth - DEPTH_W'(1);
          end
        end
      end

      FETCH: begin
        // Commands are ignored here; count down to the ram_q valid cycle.
        if (cnt_q == CNT_W'(1)) begin
          tos_d       = ram_q;
          tos_valid_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spc_stack_ctl.sv
// Self-checking bench for spc_stack_ctl. Two instances (READ_LATENCY 1 and 2)
// each sit on their own behavioural RAM; 'sel' picks which one is driven and
// observed. A reference model predicts state; pop results are queued and
// checked by a monitor when tos_valid returns.
module tb_spc_stack_ctl;

  logic        clk = 1'b0;
  logic        reset, push, pop, clr_flags, sel;
  logic [18:0] push_data;

  logic [18:0] tos1, tos2, ram_data1, ram_data2, ram_q1, ram_q2;
  logic        tv1, tv2, busy1, busy2, ovf1, ovf2, unf1, unf2;
  logic [4:0]  ptr1, ptr2, addr1, addr2;
  logic [5:0]  depth1, depth2;
  logic        wren1, wren2, rden1, rden2;
  logic        push1, push2, pop1, pop2;

  logic [18:0] tos, ram_data;
  logic        tos_valid, busy, overflow, underflow, ram_wren, ram_rden;
  logic [4:0]  spcptr, ram_address;
  logic [5:0]  depth;

  always #5 clk = ~clk;

  assign push1 = push & ~sel;
  assign pop1  = pop & ~sel;
  assign push2 = push & sel;
  assign pop2  = pop & sel;

  spc_stack_ctl #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .push(push1), .pop(pop1), .push_data(push_data),
    .clr_flags(clr_flags), .tos(tos1), .tos_valid(tv1), .busy(busy1),
    .spcptr(ptr1), .depth(depth1), .overflow(ovf1), .underflow(unf1),
    .ram_address(addr1), .ram_data(ram_data1), .ram_wren(wren1),
    .ram_rden(rden1), .ram_q(ram_q1)
  );

  spc_stack_ctl #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .push(push2), .pop(pop2), .push_data(push_data),
    .clr_flags(clr_flags), .tos(tos2), .tos_valid(tv2), .busy(busy2),
    .spcptr(ptr2), .depth(depth2), .overflow(ovf2), .underflow(unf2),
    .ram_address(addr2), .ram_data(ram_data2), .ram_wren(wren2),
    .ram_rden(rden2), .ram_q(ram_q2)
  );

  assign tos         = sel ? tos2 : tos1;
  assign tos_valid   = sel ? tv2 : tv1;
  assign busy        = sel ? busy2 : busy1;
  assign spcptr      = sel ? ptr2 : ptr1;
  assign depth       = sel ? depth2 : depth1;
  assign overflow    = sel ? ovf2 : ovf1;
  assign underflow   = sel ? unf2 : unf1;
  assign ram_address = sel ? addr2 : addr1;
  assign ram_data    = sel ? ram_data2 : ram_data1;
  assign ram_wren    = sel ? wren2 : wren1;
  assign ram_rden    = sel ? rden2 : rden1;

  // Behavioural synchronous RAMs
  logic [18:0] mem1 [32];
  logic [18:0] mem2 [32];
  logic [18:0] r1_p1, r2_p1, r2_p2;

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= ram_data1;
    if (rden1) r1_p1 <= mem1[addr1];
    if (wren2) mem2[addr2] <= ram_data2;
    if (rden2) r2_p1 <= mem2[addr2];
    r2_p2 <= r2_p1;
  end
  assign ram_q1 = r1_p1;
  assign ram_q2 = r2_p2;

  // Reference model
  logic [4:0]  m_ptr;
  int          m_depth;
  logic [18:0] m_tos;
  bit          m_ovf, m_unf;
  logic [18:0] m_mem [32];
  logic [18:0] exp_q [$];
  int          lat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          p, q, c;
    logic [18:0] d;
    logic [4:0]  e_ptr;
    logic [5:0]  e_depth;
    logic [18:0] e_tos;
    bit          e_ovf, e_unf;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    push = 0; pop = 0; clr_flags = 0; push_data = '0;
    exp_q.delete();
    reset = 1;
    tick();
    reset = 0;
    m_ptr = '0; m_depth = 0; m_tos = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".spcptr"},    32'(spcptr),    32'(m_ptr));
    check({tag, ".depth"},     32'(depth),     32'(m_depth));
    check({tag, ".tos"},       32'(tos),       32'(m_tos));
    check({tag, ".tos_valid"}, 32'(tos_valid), 32'd1);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Apply the model's effect of one accepted command.
  task automatic model_cmd(input bit p, input bit q, input bit c, input logic [18:0] d);
    if (c) begin m_ovf = 0; m_unf = 0; end
    if (p && q) begin
      m_mem[m_ptr] = d; m_tos = d;
    end else if (p) begin
      if (m_depth == 32) m_ovf = 1; else m_depth++;
      m_ptr = m_ptr + 5'd1;
      m_mem[m_ptr] = d; m_tos = d;
    end else if (q) begin
      if (m_depth == 0) m_unf = 1; else m_depth--;
      m_ptr = m_ptr - 5'd1;
      m_tos = m_mem[m_ptr];
      exp_q.push_back(m_tos);
    end
  endtask

  // Issue one command at a negedge, check the RAM request, wait for completion.
  task automatic cmd(input bit p, input bit q, input bit c, input logic [18:0] d);
    logic [4:0]  e_addr;
    logic [18:0] e_data;
    int          n;
    wait_idle();
    push = p; pop = q; clr_flags = c; push_data = d;
    #1;
    e_addr = m_ptr; e_data = '0;
    if (p && q) e_data = d;
    else if (p) begin e_addr = m_ptr + 5'd1; e_data = d; end
    else if (q) e_addr = m_ptr - 5'd1;
    check("ram_address", 32'(ram_address), 32'(e_addr));
    check("ram_data",    32'(ram_data),    32'(e_data));
    check("ram_wren",    32'(ram_wren),    32'(p));
    check("ram_rden",    32'(ram_rden),    32'(q && !p));
    model_cmd(p, q, c, d);
    tick();
    push = 0; pop = 0; clr_flags = 0; push_data = '0;
    if (q && !p) begin
      check("pop.busy",      32'(busy),      32'd1);
      check("pop.tos_valid", 32'(tos_valid), 32'd0);
      n = 0;
      while (busy && n < 10) begin
        check("fetch.strobes", 32'({ram_wren, ram_rden}), 32'd0);
        tick();
        n++;
      end
      check("busy_cycles", 32'(n), 32'(lat));
    end
    check_state("cmd");
  endtask

  // Scoreboard: compare popped TOS when tos_valid returns.
  bit tv_prev = 1'b1;
  always @(negedge clk) begin
    if (!reset && tos_valid && !tv_prev && exp_q.size() > 0) begin
      check("sb.tos", 32'(tos), 32'(exp_q.pop_front()));
    end
    tv_prev = tos_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 19'h00001, 5'd1,  6'd1, 19'h00001, 0, 0};
    vecs[1]  = '{1, 0, 0, 19'h00002, 5'd2,  6'd2, 19'h00002, 0, 0};
    vecs[2]  = '{1, 0, 0, 19'h00003, 5'd3,  6'd3, 19'h00003, 0, 0};
    vecs[3]  = '{0, 1, 0, 19'h00000, 5'd2,  6'd2, 19'h00002, 0, 0};
    vecs[4]  = '{0, 1, 0, 19'h00000, 5'd1,  6'd1, 19'h00001, 0, 0};
    vecs[5]  = '{1, 0, 0, 19'h00005, 5'd2,  6'd2, 19'h00005, 0, 0};
    vecs[6]  = '{1, 1, 0, 19'h7FFFF, 5'd2,  6'd2, 19'h7FFFF, 0, 0};
    vecs[7]  = '{0, 1, 0, 19'h00000, 5'd1,  6'd1, 19'h00001, 0, 0};
    vecs[8]  = '{0, 1, 0, 19'h00000, 5'd0,  6'd0, 19'h00000, 0, 0};
    vecs[9]  = '{0, 1, 0, 19'h00000, 5'd31, 6'd0, 19'h00000, 0, 1};
    vecs[10] = '{0, 0, 1, 19'h00000, 5'd31, 6'd0, 19'h00000, 0, 0};
    vecs[11] = '{0, 1, 1, 19'h00000, 5'd30, 6'd0, 19'h00000, 0, 1};
    vecs[12] = '{0, 0, 1, 19'h00000, 5'd30, 6'd0, 19'h00000, 0, 0};
    vecs[13] = '{1, 0, 0, 19'h45A5A, 5'd31, 6'd1, 19'h45A5A, 0, 0};

    for (int i = 0; i < 32; i++) begin
      mem1[i] = '0; mem2[i] = '0; m_mem[i] = '0;
    end
    r1_p1 = '0; r2_p1 = '0; r2_p2 = '0;
    sel = 0; lat = 1;
    reset = 1; push = 0; pop = 0; clr_flags = 0; push_data = '0;
    @(negedge clk);
    do_reset();
    check_state("reset");
    check("reset.strobes", 32'({ram_wren, ram_rden}), 32'd0);

    // Table-driven sequence on the latency-1 instance
    for (int i = 0; i < 14; i++) begin
      cmd(vecs[i].p, vecs[i].q, vecs[i].c, vecs[i].d);
      check($sformatf("vec%0d.spcptr", i),    32'(spcptr),    32'(vecs[i].e_ptr));
      check($sformatf("vec%0d.depth", i),     32'(depth),     32'(vecs[i].e_depth));
      check($sformatf("vec%0d.tos", i),       32'(tos),       32'(vecs[i].e_tos));
      check($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
      if (i == 2) begin
        check("ram1[1]", 32'(mem1[1]), 32'h1);
        check("ram1[2]", 32'(mem1[2]), 32'h2);
        check("ram1[3]", 32'(mem1[3]), 32'h3);
      end
    end
    check("replace.ram1[2]", 32'(mem1[2]), 32'h7FFFF);

    // 33 pushes from reset: overflow at the last one, then clear
    do_reset();
    for (int i = 0; i <= 32; i++) cmd(1, 0, 0, 19'(i));
    check("ovf33.overflow", 32'(overflow), 32'd1);
    check("ovf33.depth",    32'(depth),    32'd32);
    check("ovf33.spcptr",   32'(spcptr),   32'd1);
    check("ovf33.tos",      32'(tos),      32'd32);
    cmd(0, 0, 1, '0);
    check("ovf33.cleared",  32'(overflow), 32'd0);

    // Pop from reset: underflow, pointer wraps to 31, RAM[31] read
    do_reset();
    cmd(0, 1, 0, '0);
    check("unf.underflow", 32'(underflow), 32'd1);
    check("unf.spcptr",    32'(spcptr),    32'd31);
    check("unf.depth",     32'(depth),     32'd0);
    check("unf.tos",       32'(tos),       32'(mem1[31]));

    // Latency-2 instance
    sel = 1; lat = 2;
    for (int i = 0; i < 32; i++) m_mem[i] = mem2[i];
    do_reset();
    check_state("reset2");
    cmd(1, 0, 0, 19'h00011);
    cmd(1, 0, 0, 19'h00022);
    cmd(0, 1, 0, '0);

    // Pop with push held during FETCH: push waits for busy=0
    cmd(1, 0, 0, 19'h00022);
    pop = 1;
    #1;
    check("hold.rden", 32'(ram_rden), 32'd1);
    model_cmd(0, 1, 0, '0);
    tick();
    pop = 0; push = 1; push_data = 19'h00033;
    begin
      int n;
      n = 0;
      while (busy && n < 10) begin
        #1;
        check("hold.wren_ignored", 32'(ram_wren), 32'd0);
        check("hold.spcptr",       32'(spcptr),   32'd1);
        tick();
        n++;
      end
      check("hold.busy_cycles", 32'(n), 32'd2);
    end
    #1;
    check("hold.tos_fetched", 32'(tos),         32'h00011);
    check("hold.wren",        32'(ram_wren),    32'd1);
    check("hold.address",     32'(ram_address), 32'd2);
    model_cmd(1, 0, 0, 19'h00033);
    tick();
    push = 0; push_data = '0;
    check_state("hold.after");
    check("hold.ram2[2]", 32'(mem2[2]), 32'h00033);

    // Reset mid-FETCH: fetch aborted, late ram_q discarded
    cmd(1, 0, 0, 19'h00044);
    pop = 1;
    model_cmd(0, 1, 0, '0);
    tick();
    pop = 0;
    check("abort.busy", 32'(busy), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check_state("abort");
      tick();
    end

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
